// File: rtl/uart_tx_frame_if.sv
// Byte-stream handshake between a producer and uart_tx_frame.
// The producer drives data/valid and sees ready; the transmitter is the slave.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload (either bit
// order), optional parity, STOP_BITS stop bits, internal baud divider and a
// valid/ready handshake that allows back-to-back frames with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit
// (^payload ^ PARITY_ODD) between the payload and the stop bits.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int LSB_FIRST    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 nReset,
  uart_tx_frame_if.slave       bus,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration rather than misbehaving.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic bit_end;
  logic ready;
  logic handshake;

  // ready opens in IDLE and in the very last cycle of the last stop bit so a
  // waiting word can start the next frame with no gap.
  assign bit_end   = (baud_cnt_q == BAUD_LAST);
  assign ready     = (state_q == IDLE) ||
                     ((state_q == STOP) && (bit_cnt_q == STOP_LAST) && bit_end);
  assign handshake = bus.valid && ready;

  assign bus.ready = ready;
  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state logic; out is derived from the next state so the line is registered.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d    = START;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = bus.data;
          busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = (^bus.data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (LSB_FIRST != 0) begin
              shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            end else begin
              shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
            end
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (handshake) begin
              state_d  = START;
              shift_d  = bus.data;
`ifdef UART_TX_PARITY_EN
              parity_d = (^bus.data) ^ 1'(PARITY_ODD);
`endif
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = (LSB_FIRST != 0) ? shift_d[0] : shift_d[DATA_BITS-1];
`ifdef UART_TX_PARITY_EN
      PARITY:  out_d = parity_d;
`endif
      default: out_d = 1'b1;
    endcase
  end

  // State, counters and line register; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      out_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It adds:
- configurable data width, stop-bit count and bit order;
- an internal baud-rate divider;
- a valid/ready handshake that allows back-to-back frames with no idle gap;
- optional parity insertion.

It sits between a byte-stream producer (FIFO or bus bridge) and the serial TX pin.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal 5..9
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 1
- LSB_FIRST, 1, 1 = data[0] sent first, 0 = data[DATA_BITS-1] sent first
- PARITY_ODD, 0, parity sense when parity is compiled in (0 even, 1 odd); ignored otherwise

Ports:
- clk  input  1  clock
- nReset  input  1  asynchronous, active-low reset
- data  input  DATA_BITS  payload, sampled only on handshake
- valid  input  1  producer has a word on data
- ready  output  1  block accepts data this cycle
- out  output  1  serial line, idle high
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse: a frame has completed

Behaviour:
- Reset: clk and nReset (asynchronous, active-low). On assertion, out=1, busy=0, done=0, state=IDLE, all counters 0. ready=1 once in IDLE.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Each state holds out for CLKS_PER_BIT cycles per bit, timed by baudCnt (0..CLKS_PER_BIT-1, width max(1,$clog2(CLKS_PER_BIT))). bitCnt has width $clog2(DATA_BITS+1).
- Handshake: transfer occurs when valid && ready on a clk edge.
  - data is latched into a shift register on that edge.
  - data need not stay stable afterwards.
- ready is combinational:
  - high in IDLE;
  - high during the final clk of the last stop bit (STOP, last stop bit, baudCnt==CLKS_PER_BIT-1);
  - low otherwise.
  - valid while ready=0 is ignored; nothing is queued.
- Latency: handshake on edge N gives out=0 (start bit) from cycle N+1. out is registered and glitch-free.
- Transitions:
  - IDLE -> START on handshake.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: shift one bit per CLKS_PER_BIT cycles; after DATA_BITS bits go to PARITY if present, else STOP.
  - PARITY -> STOP after one bit time.
  - STOP lasts STOP_BITS*CLKS_PER_BIT cycles. It ends in START if a handshake occurred in its final cycle, else IDLE.
- out values per state:
  - START: 0
  - DATA: current bit per LSB_FIRST
  - PARITY: computed parity
  - STOP and IDLE: 1
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity, 0 without.
- done: registered, high exactly one cycle, the cycle after the final stop-bit cycle. In back-to-back operation it coincides with the first start-bit cycle of the next frame.
- busy: high from cycle N+1 through the final stop-bit cycle. It stays high across back-to-back frames.
- CLKS_PER_BIT=1: every bit lasts one cycle. Back-to-back still has zero gap.
- Reset mid-frame aborts the frame: out=1 at once, no done pulse, the partial word is discarded.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state is inserted between DATA and STOP.
  - Parity bit = ^payload XOR PARITY_ODD.
  - Frame grows by one bit time.
- Undefined: no PARITY state or parity logic. DATA goes directly to STOP. PARITY_ODD is unused.

Test Plan:
All scenarios use DATA_BITS=8, STOP_BITS=1, CLKS_PER_BIT=4, LSB_FIRST=1 unless stated.
1. Reset asserted, then released with valid=0 -> out=1, busy=0, done=0, ready=1, held indefinitely.
2. Single handshake with data=0xA5 at edge 0:
   - out=0 in cycles 1-4;
   - bits 1,0,1,0,0,1,0,1 each for 4 cycles over cycles 5-36;
   - stop 1 in cycles 37-40;
   - done=1 in cycle 41 only, busy=0 from cycle 41.
3. valid held with 0x00 then 0xFF -> ready=1 in cycle 40, the second start bit begins in cycle 41 with no idle gap, busy stays 1, done pulses in cycle 41.
4. valid=1 with data=0x3C in cycles 10-20 during a frame (ready=0) -> no second frame, out=1 after cycle 40, exactly one done pulse.
5. nReset pulsed low in cycle 15 mid-frame -> out=1 and busy=0 immediately, no done. A new 0x5A handshake afterwards produces a clean 40-cycle frame.
6. UART_TX_PARITY_EN defined, PARITY_ODD=0, STOP_BITS=2, data=0x07:
   - parity bit 1 in cycles 37-40;
   - stop 1 in cycles 41-48;
   - done in cycle 49.
   - With PARITY_ODD=1 the parity bit is 0.
